regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between three writeback sources: load unit (ld), ALU (alu) and debug host (dbg).
- Each source has a one-entry holding slot with a valid/ready handshake.
- Grants one slot per cycle by fixed priority, with anti-starvation promotion for dbg.
- Drives registered write_enable/write_addr/write_data into the register file and exports a pending-write mask for issue hazard checks.

Parameters:
- DATA_W, 32, write data width.
- ADDR_W, 6, write address width; matches the register file address ports.
- NREGS, 32, number of implemented registers; addresses >= NREGS are out of range.
- STARVE_LIMIT, 4, consecutive cycles a full dbg slot may lose arbitration before it is promoted.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ld_valid  in  1  load writeback request.
- ld_ready  out  1  load slot can accept.
- ld_addr  in  ADDR_W  load destination register.
- ld_data  in  DATA_W  load writeback data.
- alu_valid  in  1  ALU writeback request.
- alu_ready  out  1  ALU slot can accept.
- alu_addr  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU writeback data.
- dbg_valid  in  1  debug write request.
- dbg_ready  out  1  debug slot can accept.
- dbg_addr  in  ADDR_W  debug destination register.
- dbg_data  in  DATA_W  debug write data.
- rf_we  out  1  register file write_enable.
- rf_waddr  out  ADDR_W  register file write_addr.
- rf_wdata  out  DATA_W  register file write_data.
- pending_mask  out  NREGS  bit i = a write to register i is queued or being issued.
- drop_err  out  1  one-cycle pulse when an out-of-range write is discarded.

Behaviour:
- Reset (synchronous, clk rising edge with reset=1):
  - All slots emptied, dbg starve counter cleared.
  - rf_we=0, rf_waddr=0, rf_wdata=0, pending_mask=0, drop_err=0.
  - ld_ready/alu_ready/dbg_ready held 0 while reset=1.
  - Reset mid-operation discards slot contents and any staged write; no regfile write occurs.
- Slot ready (per source x): x_ready = !full_x || grant_x (same-cycle drain allows back-to-back accepts).
- Accept: on a clk edge with x_valid && x_ready, the slot captures {addr, data}.
- Out-of-range request (addr >= NREGS):
  - Still handshaken (ready unaffected) but never stored.
  - drop_err=1 in the cycle after the accept edge.
  - Multiple drops in the same cycle produce a single pulse.
- Grant (combinational, from full slots):
  - Normal order: ld > alu > dbg.
  - If the starve counter == STARVE_LIMIT, dbg wins over all.
  - At most one grant per cycle.
- Starve counter:
  - Increments each cycle dbg is full and not granted; saturates at STARVE_LIMIT.
  - Cleared on dbg grant or when the dbg slot is empty.
- Issue stage (registered):
  - On the edge where slot x is granted: rf_we<=1, rf_waddr<=addr_x, rf_wdata<=data_x, slot x empties (unless refilled same edge).
  - With no grant: rf_we<=0; rf_waddr/rf_wdata hold previous values.
- Latency:
  - Request accepted at edge N: with no contention, granted in cycle N..N+1, rf_we high in cycle N+1..N+2, regfile written at edge N+2.
  - Each cycle of lost arbitration adds one cycle.
- Throughput: one regfile write per cycle sustained when any slot is full.
- pending_mask: OR of one-hot(addr) over full slots and one-hot(rf_waddr) when rf_we=1; recomputed every cycle (registered or combinational, but consistent with slot/issue state each cycle).
- Same-register conflict: multiple queued writes to one register issue in grant order; the last issued value wins. Issue logic must use pending_mask to avoid relying on inter-source order.
- Register 0 is not special-cased; writes to any in-range address are passed through.

Test Plan:
- Reset then idle -> all readys 1 after reset deasserts; rf_we=0, pending_mask=0, drop_err=0 for 10 cycles.
- Single alu write addr=5, data=0xDEADBEEF at edge N -> rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF in cycle N+1; pending_mask bit 5 set from N+1 until rf_we drops.
- ld (addr=3, data=0x11), alu (addr=4, data=0x22) and dbg (addr=7, data=0x33) all valid in one cycle -> writes issue on consecutive cycles in order 3, 4, 7; no readys stall after the first cycle.
- dbg full while ld and alu stream continuously with STARVE_LIMIT=4 -> dbg granted on the 5th cycle after becoming full; starve counter clears afterwards.
- alu_addr=40 (>= NREGS) -> alu_ready=1, no rf_we, drop_err=1 for exactly one cycle, pending_mask unchanged.
- reset asserted while all three slots are full -> no rf_we after reset; slots empty, pending_mask=0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file's single write port.
// It holds one entry each for the load unit, the ALU and the debug host, and issues one write per cycle.
module regfile_wb_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 6,
    parameter int NREGS        = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              dbg_valid,
    output logic              dbg_ready,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [NREGS-1:0]  pending_mask,
    output logic              drop_err
);

    localparam int NSRC  = 3;
    localparam int LD    = 0;
    localparam int ALU   = 1;
    localparam int DBG   = 2;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [ADDR_W:0]  NREGS_W   = (ADDR_W + 1)'(NREGS);
    localparam logic [CNT_W-1:0] LIMIT_CNT = CNT_W'(STARVE_LIMIT);

    logic [NSRC-1:0]   in_valid, in_range, full, grant, ready, fire;
    logic [ADDR_W-1:0] in_addr   [NSRC];
    logic [DATA_W-1:0] in_data   [NSRC];
    logic [ADDR_W-1:0] slot_addr [NSRC];
    logic [DATA_W-1:0] slot_data [NSRC];
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic [CNT_W-1:0]  starve_cnt;
    logic              promote;

    always_comb begin
        in_valid     = {dbg_valid, alu_valid, ld_valid};
        in_addr[LD]  = ld_addr;
        in_addr[ALU] = alu_addr;
        in_addr[DBG] = dbg_addr;
        in_data[LD]  = ld_data;
        in_data[ALU] = alu_data;
        in_data[DBG] = dbg_data;
        for (int s = 0; s < NSRC; s++) begin
            in_range[s] = {1'b0, in_addr[s]} < NREGS_W;
        end
    end

    // A dbg entry that has lost STARVE_LIMIT times in a row overrides fixed priority.
    always_comb begin
        promote    = full[DBG] && (starve_cnt == LIMIT_CNT);
        grant[LD]  = full[LD] && !promote;
        grant[ALU] = full[ALU] && !full[LD] && !promote;
        grant[DBG] = full[DBG] && (promote || (!full[LD] && !full[ALU]));
        ready      = reset ? '0 : (~full | grant);
        fire       = in_valid & ready;
    end

    assign ld_ready  = ready[LD];
    assign alu_ready = ready[ALU];
    assign dbg_ready = ready[DBG];

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        sel_addr = slot_addr[LD];
        sel_data = slot_data[LD];
        if (grant[ALU]) begin
            sel_addr = slot_addr[ALU];
            sel_data = slot_data[ALU];
        end
        if (grant[DBG]) begin
            sel_addr = slot_addr[DBG];
            sel_data = slot_data[DBG];
        end
    end

    // NOTE: state updates use non-blocking assignments, so every read in this block sees the pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            full       <= '0;
            starve_cnt <= '0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            drop_err   <= 1'b0;
        end else begin
            for (int s = 0; s < NSRC; s++) begin
                if (fire[s] && in_range[s]) begin
                    full[s] <= 1'b1;
                end else if (grant[s]) begin
                    full[s] <= 1'b0;
                end
            end
            drop_err <= |(fire & ~in_range);
            if (!full[DBG] || grant[DBG]) begin
                starve_cnt <= '0;
            end else if (starve_cnt != LIMIT_CNT) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
            rf_we <= |grant;
            if (|grant) begin
                rf_waddr <= sel_addr;
                rf_wdata <= sel_data;
            end
        end
    end

    // NOTE: slot payloads have no reset; the full bits alone decide whether a payload is meaningful.
    always_ff @(posedge clk) begin
        for (int s = 0; s < NSRC; s++) begin
            if (fire[s] && in_range[s]) begin
                slot_addr[s] <= in_addr[s];
                slot_data[s] <= in_data[s];
            end
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int r = 0; r < NREGS; r++) begin
            for (int s = 0; s < NSRC; s++) begin
                if (full[s] && slot_addr[s] == ADDR_W'(r)) pending_mask[r] = 1'b1;
            end
            if (rf_we && rf_waddr == ADDR_W'(r)) pending_mask[r] = 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scenario bench for regfile_wb_arbiter.
// A queue holds the register writes expected in issue order, and a negedge monitor pops and compares them.
module tb_regfile_wb_arbiter;

    localparam int DATA_W = 32, ADDR_W = 6, NREGS = 32, STARVE_LIMIT = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              ld_valid, alu_valid, dbg_valid;
    logic              ld_ready, alu_ready, dbg_ready;
    logic [ADDR_W-1:0] ld_addr, alu_addr, dbg_addr;
    logic [DATA_W-1:0] ld_data, alu_data, dbg_data;
    logic              rf_we, drop_err;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [NREGS-1:0]  pending_mask;

    wr_t sb[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    bit  mon_en = 1'b0;

    regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pending_mask(pending_mask), .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    // Every issued write must match the head of the scoreboard.
    always @(negedge clk) begin
        wr_t e;
        if (mon_en && rf_we === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, queue empty", rf_waddr, rf_wdata);
            end else begin
                e = sb.pop_front();
                if (rf_waddr !== e.addr || rf_wdata !== e.data) begin
                    n_bad++;
                    $display("FAIL write_order: got addr=%0d data=%h want addr=%0d data=%h",
                             rf_waddr, rf_wdata, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        ld_valid = 1'b0; alu_valid = 1'b0; dbg_valid = 1'b0;
        ld_addr = '0; alu_addr = '0; dbg_addr = '0;
        ld_data = '0; alu_data = '0; dbg_data = '0;
    endtask

    task automatic push(input int a, input logic [DATA_W-1:0] d);
        wr_t w;
        w.addr = ADDR_W'(a);
        w.data = d;
        sb.push_back(w);
    endtask

    function automatic logic [NREGS-1:0] bits(input int a, input int b, input int c);
        logic [NREGS-1:0] m;
        m = '0;
        if (a >= 0) m[a] = 1'b1;
        if (b >= 0) m[b] = 1'b1;
        if (c >= 0) m[c] = 1'b1;
        return m;
    endfunction

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while (sb.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain_timeout: got %0d writes outstanding want 0", sb.size());
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({ld_ready, alu_ready, dbg_ready} !== 3'b000) begin
            n_bad++;
            $display("FAIL ready_in_reset: got %b want 000", {ld_ready, alu_ready, dbg_ready});
        end
        reset = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if ({ld_ready, alu_ready, dbg_ready, rf_we, drop_err} !== 5'b11100 || pending_mask !== '0) begin
                n_bad++;
                $display("FAIL idle_state c%0d: got rdy=%b we=%b drop=%b mask=%h want rdy=111 we=0 drop=0 mask=0",
                         i, {ld_ready, alu_ready, dbg_ready}, rf_we, drop_err, pending_mask);
            end
        end
    endtask

    task automatic test_single_alu();
        push(5, 32'hDEADBEEF);
        alu_valid = 1'b1; alu_addr = 6'd5; alu_data = 32'hDEADBEEF;
        #1;
        n_cmp++;
        if (alu_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL single_ready: got %b want 1", alu_ready);
        end
        tick();
        idle();
        n_cmp++;
        if (rf_we !== 1'b0 || pending_mask !== bits(5, -1, -1)) begin
            n_bad++;
            $display("FAIL single_slot: got we=%b mask=%h want we=0 mask=%h", rf_we, pending_mask, bits(5, -1, -1));
        end
        tick();
        n_cmp++;
        if (rf_we !== 1'b1 || rf_waddr !== 6'd5 || rf_wdata !== 32'hDEADBEEF || pending_mask !== bits(5, -1, -1)) begin
            n_bad++;
            $display("FAIL single_issue: got we=%b addr=%0d data=%h mask=%h want we=1 addr=5 data=deadbeef mask=%h",
                     rf_we, rf_waddr, rf_wdata, pending_mask, bits(5, -1, -1));
        end
        tick();
        n_cmp++;
        if (rf_we !== 1'b0 || pending_mask !== '0) begin
            n_bad++;
            $display("FAIL single_done: got we=%b mask=%h want we=0 mask=0", rf_we, pending_mask);
        end
        wait_drain(5);
    endtask

    task automatic test_all_three();
        push(3, 32'h11); push(4, 32'h22); push(7, 32'h33);
        ld_valid = 1'b1;  ld_addr = 6'd3;  ld_data = 32'h11;
        alu_valid = 1'b1; alu_addr = 6'd4; alu_data = 32'h22;
        dbg_valid = 1'b1; dbg_addr = 6'd7; dbg_data = 32'h33;
        tick();
        idle();
        n_cmp++;
        if (pending_mask !== bits(3, 4, 7) || {ld_ready, alu_ready, dbg_ready} !== 3'b100) begin
            n_bad++;
            $display("FAIL three_queued: got mask=%h rdy=%b want mask=%h rdy=100",
                     pending_mask, {ld_ready, alu_ready, dbg_ready}, bits(3, 4, 7));
        end
        for (int c = 1; c <= 3; c++) begin
            tick();
            n_cmp++;
            if (rf_we !== 1'b1) begin
                n_bad++;
                $display("FAIL three_consecutive c%0d: got we=%b want 1", c, rf_we);
            end
            if (c == 2) begin
                n_cmp++;
                if ({ld_ready, alu_ready, dbg_ready} !== 3'b111) begin
                    n_bad++;
                    $display("FAIL three_readys: got %b want 111", {ld_ready, alu_ready, dbg_ready});
                end
            end
        end
        wait_drain(5);
    endtask

    task automatic test_starvation();
        int  li, cyc, dbg_seen;
        bit  a_done, d_done;
        for (int k = 0; k < 4; k++) push(8 + k, 32'hA000 + k);
        push(21, 32'hD0);
        push(12, 32'hA004); push(13, 32'hA005);
        push(20, 32'hB0);
        li = 0; cyc = 0; dbg_seen = -1; a_done = 1'b0; d_done = 1'b0;
        while ((li < 6 || !a_done || !d_done) && cyc < 40) begin
            ld_valid  = (li < 6);
            ld_addr   = ADDR_W'(8 + li);
            ld_data   = 32'hA000 + 32'(li);
            alu_valid = !a_done; alu_addr = 6'd20; alu_data = 32'hB0;
            dbg_valid = !d_done; dbg_addr = 6'd21; dbg_data = 32'hD0;
            #1;
            if (ld_valid && ld_ready) li++;
            if (alu_valid && alu_ready) a_done = 1'b1;
            if (dbg_valid && dbg_ready) d_done = 1'b1;
            tick();
            if (cyc == 4) begin
                n_cmp++;
                if (dut.starve_cnt !== 3'd4) begin
                    n_bad++;
                    $display("FAIL starve_at_limit: got %0d want 4", dut.starve_cnt);
                end
            end
            if (rf_we === 1'b1 && rf_waddr === 6'd21) begin
                dbg_seen = cyc;
                n_cmp++;
                if (dut.starve_cnt !== 3'd0) begin
                    n_bad++;
                    $display("FAIL starve_clear: got %0d want 0", dut.starve_cnt);
                end
            end
            cyc++;
        end
        idle();
        n_cmp++;
        if (dbg_seen != 5) begin
            n_bad++;
            $display("FAIL dbg_promote_cycle: got %0d want 5", dbg_seen);
        end
        wait_drain(10);
    endtask

    task automatic test_drop();
        alu_valid = 1'b1; alu_addr = 6'd40; alu_data = 32'h5A5A;
        #1;
        n_cmp++;
        if (alu_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL drop_ready: got %b want 1", alu_ready);
        end
        tick();
        idle();
        n_cmp++;
        if (drop_err !== 1'b1 || rf_we !== 1'b0 || pending_mask !== '0) begin
            n_bad++;
            $display("FAIL drop_pulse: got drop=%b we=%b mask=%h want drop=1 we=0 mask=0", drop_err, rf_we, pending_mask);
        end
        tick();
        n_cmp++;
        if (drop_err !== 1'b0 || rf_we !== 1'b0) begin
            n_bad++;
            $display("FAIL drop_once: got drop=%b we=%b want drop=0 we=0", drop_err, rf_we);
        end
        // Two drops together give one pulse; register NREGS-1 is still in range.
        push(31, 32'h31);
        ld_valid = 1'b1;  ld_addr = 6'd32;  ld_data = 32'h1;
        dbg_valid = 1'b1; dbg_addr = 6'd63; dbg_data = 32'h2;
        alu_valid = 1'b1; alu_addr = 6'd31; alu_data = 32'h31;
        tick();
        idle();
        n_cmp++;
        if (drop_err !== 1'b1 || pending_mask !== bits(31, -1, -1)) begin
            n_bad++;
            $display("FAIL drop_multi: got drop=%b mask=%h want drop=1 mask=%h", drop_err, pending_mask, bits(31, -1, -1));
        end
        tick();
        n_cmp++;
        if (drop_err !== 1'b0 || rf_we !== 1'b1) begin
            n_bad++;
            $display("FAIL drop_multi_next: got drop=%b we=%b want drop=0 we=1", drop_err, rf_we);
        end
        wait_drain(5);
    endtask

    task automatic test_back_to_back();
        int n;
        logic [ADDR_W-1:0] addrs [4];
        addrs[0] = 6'd9; addrs[1] = 6'd9; addrs[2] = 6'd2; addrs[3] = 6'd0;
        for (int k = 0; k < 4; k++) push(int'(addrs[k]), 32'hC0 + 32'(k));
        n = 0;
        for (int k = 0; k < 4; k++) begin
            alu_valid = 1'b1; alu_addr = addrs[k]; alu_data = 32'hC0 + 32'(k);
            #1;
            if (alu_ready === 1'b1) n++;
            tick();
            if (k >= 1) begin
                n_cmp++;
                if (rf_we !== 1'b1) begin
                    n_bad++;
                    $display("FAIL b2b_rate k%0d: got we=%b want 1", k, rf_we);
                end
            end
        end
        idle();
        n_cmp++;
        if (n != 4) begin
            n_bad++;
            $display("FAIL b2b_ready: got %0d accepts want 4", n);
        end
        wait_drain(6);
    endtask

    task automatic test_reset_mid();
        ld_valid = 1'b1;  ld_addr = 6'd10; ld_data = 32'hE0;
        alu_valid = 1'b1; alu_addr = 6'd11; alu_data = 32'hE1;
        dbg_valid = 1'b1; dbg_addr = 6'd12; dbg_data = 32'hE2;
        tick();
        idle();
        n_cmp++;
        if (pending_mask !== bits(10, 11, 12)) begin
            n_bad++;
            $display("FAIL mid_full: got mask=%h want %h", pending_mask, bits(10, 11, 12));
        end
        reset = 1'b1;
        tick();
        n_cmp++;
        if ({ld_ready, alu_ready, dbg_ready} !== 3'b000 || rf_we !== 1'b0 || pending_mask !== '0) begin
            n_bad++;
            $display("FAIL mid_reset: got rdy=%b we=%b mask=%h want rdy=000 we=0 mask=0",
                     {ld_ready, alu_ready, dbg_ready}, rf_we, pending_mask);
        end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (rf_we !== 1'b0 || pending_mask !== '0 || {ld_ready, alu_ready, dbg_ready} !== 3'b111) begin
                n_bad++;
                $display("FAIL mid_after c%0d: got we=%b mask=%h rdy=%b want we=0 mask=0 rdy=111",
                         i, rf_we, pending_mask, {ld_ready, alu_ready, dbg_ready});
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        idle();
        tick();
        test_reset();
        test_single_alu();
        test_all_three();
        test_starvation();
        test_drop();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
